// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and perf signals of the fetch/data memory port arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [15:0]       perf_if_wait;
    logic [15:0]       perf_dm_wait;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, perf_if_wait, perf_dm_wait
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_done, if_rdata, if_stall, dm_done, dm_rdata, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, perf_if_wait, perf_dm_wait
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data single-port memory arbiter; MEM_ARB_PERF_CNT_EN builds stall counters
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave io_bus
);
    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [LAT_W-1:0]   r_lat_cnt;
    logic [STV_W-1:0]   r_starve;
    logic               r_mem_en;
    logic               r_mem_we;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [DATA_W-1:0]  r_mem_wdata;
    logic [DATA_W-1:0]  r_if_rdata;
    logic [DATA_W-1:0]  r_dm_rdata;
    logic               w_force_if;
    logic               w_grant_dm;
    logic               w_grant_if;
    logic               w_if_done;
    logic               w_dm_done;

    assign w_force_if = io_bus.if_req && (r_starve == STV_W'(STARVE_MAX));
    assign w_grant_dm = (r_state == IDLE) && io_bus.dm_req && !w_force_if;
    assign w_grant_if = (r_state == IDLE) && io_bus.if_req && !w_grant_dm;

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_dm)      w_state_nxt = BUSY_DM;
                else if (w_grant_if) w_state_nxt = BUSY_IF;
            end
            BUSY_IF, BUSY_DM: if (r_lat_cnt == '0) w_state_nxt = IDLE;
            default:          w_state_nxt = IDLE;
        endcase
    end

    // A reset landing on the done cycle must still suppress the pulse.
    always_comb begin
        w_if_done = 1'b0;
        w_dm_done = 1'b0;
        if (!reset && r_lat_cnt == '0) begin
            w_if_done = (r_state == BUSY_IF);
            w_dm_done = (r_state == BUSY_DM);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_cnt   <= '0;
            r_starve    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_mem_en <= w_grant_dm || w_grant_if;
            if (w_grant_dm || w_grant_if) begin
                r_mem_we    <= w_grant_dm && io_bus.dm_we;
                r_mem_addr  <= w_grant_dm ? io_bus.dm_addr : io_bus.if_addr;
                r_mem_wdata <= w_grant_dm ? io_bus.dm_wdata : '0;
                r_lat_cnt   <= LAT_W'(MEM_LAT);
            end else if (r_lat_cnt != '0) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end
            if (w_if_done) r_if_rdata <= io_bus.mem_rdata;
            if (w_dm_done) r_dm_rdata <= r_mem_we ? '0 : io_bus.mem_rdata;
            if (w_grant_if || !io_bus.if_req)
                r_starve <= '0;
            else if (w_grant_dm && r_starve != STV_W'(STARVE_MAX))
                r_starve <= r_starve + 1'b1;
        end
    end

    assign io_bus.mem_en    = r_mem_en;
    assign io_bus.mem_we    = r_mem_we;
    assign io_bus.mem_addr  = r_mem_addr;
    assign io_bus.mem_wdata = r_mem_wdata;
    assign io_bus.if_done   = w_if_done;
    assign io_bus.dm_done   = w_dm_done;
    assign io_bus.if_rdata  = w_if_done ? io_bus.mem_rdata : r_if_rdata;
    assign io_bus.dm_rdata  = w_dm_done ? (r_mem_we ? '0 : io_bus.mem_rdata) : r_dm_rdata;
    assign io_bus.if_stall  = io_bus.if_req && !w_if_done;
    assign io_bus.dm_stall  = io_bus.dm_req && !w_dm_done;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [15:0] r_perf_if_wait;
    logic [15:0] r_perf_dm_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_if_wait <= '0;
            r_perf_dm_wait <= '0;
        end else begin
            if (io_bus.if_stall && r_perf_if_wait != 16'hFFFF) r_perf_if_wait <= r_perf_if_wait + 16'd1;
            if (io_bus.dm_stall && r_perf_dm_wait != 16'hFFFF) r_perf_dm_wait <= r_perf_dm_wait + 16'd1;
        end
    end

    assign io_bus.perf_if_wait = r_perf_if_wait;
    assign io_bus.perf_dm_wait = r_perf_dm_wait;
`else
    assign io_bus.perf_if_wait = '0;
    assign io_bus.perf_dm_wait = '0;
`endif
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter sharing one single-ported memory between the instruction-fetch stage and the data-memory stage of the pipelined core. Data accesses win by default; a starvation counter forces a fetch grant after repeated losses. It sequences each access through a fixed-latency memory, returns read data with a one-cycle done pulse, and drives per-requester stall lines to the hazard logic.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory read latency in cycles (≥1)
- STARVE_MAX, 4, consecutive fetch losses before fetch is forced (≥1)

- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_done  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_W  fetch data
- if_stall  out  1  if_req && !if_done
- dm_req  in  1  data request; held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_done  out  1  one-cycle pulse (reads and writes)
- dm_rdata  out  DATA_W  read data (0 on writes)
- dm_stall  out  1  dm_req && !dm_done
- mem_en  out  1  one-cycle access strobe
- mem_we  out  1  write enable, qualified by mem_en
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  valid MEM_LAT cycles after the mem_en cycle
- perf_if_wait, perf_dm_wait  out  16 each  stall-cycle counters (see Configuration)

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, at a clock edge: if an owner is chosen, register mem_en=1, mem_we, mem_addr, mem_wdata (wdata=0 for fetch), load lat_cnt=MEM_LAT, enter BUSY_x.
- Owner selection: dm_req && !(if_req && starve==STARVE_MAX) → DM; else if_req → IF; else stay IDLE.
- starve: +1 when both requests are high and DM wins; cleared when IF is granted or if_req is low; saturates at STARVE_MAX.
- BUSY_x: mem_en=0 after its first cycle; lat_cnt decrements each cycle; at lat_cnt==0 pulse x_done with x_rdata=mem_rdata (dm_rdata=0 for writes), next state IDLE.
- No arbitration in BUSY states; the done cycle does not grant.
- Requester dropping req mid-access: access completes, done still pulses, data is discarded by the requester.
- if_rdata/dm_rdata hold the last value between done pulses.
- Reset: state IDLE; starve=0, lat_cnt=0; mem_en, mem_we, if_done, dm_done=0; mem_addr, mem_wdata, if_rdata, dm_rdata, perf counters=0. A reset during BUSY abandons the access: no done pulse, and late mem_rdata is ignored.

## Timing
- Request high at edge E0 in IDLE → mem_en high in cycle 1 → done high in cycle 1+MEM_LAT → IDLE in cycle 2+MEM_LAT → next mem_en no earlier than cycle 3+MEM_LAT.
- Throughput: one access per MEM_LAT+2 cycles.
- Stalls are combinational from req and done; they drop in the done cycle.
- Simultaneous requests in IDLE: one grant per edge; the loser stays stalled.

## Configuration
- MEM_ARB_PERF_CNT_EN defined: perf_if_wait and perf_dm_wait are 16-bit counters that increment in every cycle the matching stall is high, saturate at 0xFFFF, and clear on reset.
- MEM_ARB_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built. Arbitration is identical either way.

## Test plan
All scenarios use MEM_LAT=2 and STARVE_MAX=3.
- Single fetch: if_req=1, if_addr=0x10, edge 0 → mem_en=1, mem_addr=0x10 in cycle 1; if_done=1 with if_rdata=mem_rdata in cycle 3; if_stall low in cycle 3.
- Data write: dm_req=1, dm_we=1, dm_addr=0x40, dm_wdata=0xA5 → mem_we=1, mem_wdata=0xA5 in cycle 1; dm_done=1 with dm_rdata=0 in cycle 3.
- Contention: if_req and dm_req held high → DM, DM, DM, then IF is forced on the fourth grant; starve returns to 0; grants are spaced 4 cycles apart.
- Back-to-back: dm_req held with new addresses → mem_en in cycles 1, 5, 9; no grant in any done cycle.
- Reset mid-access: reset asserted in cycle 2 of BUSY_DM → no dm_done; all outputs 0 next cycle; IDLE; a pending if_req is granted after reset deasserts.
- Perf counters (macro on): 10 contention cycles → perf_if_wait equals the IF stall-cycle count; preload near 0xFFFF and confirm it saturates. With the macro off, both ports read 0.
